// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, req/ready imem handshake, next-PC select
// Optional jump target logic: define IFETCH_JUMP_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrReg,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [15:0] const_imm,
    input  logic [25:0] address,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc4;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    assign pc4        = pc_q + 32'd4;
    assign branch_off = {{14{const_imm[15]}}, const_imm, 2'b00};

`ifdef IFETCH_JUMP_EN
    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = {pc4[31:28], address, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc4 + branch_off;
        end
    end
`else
    logic unused_jump_inputs;
    assign unused_jump_inputs = ^{jump, address};

    always_comb begin
        next_pc = pc4;
        if (branch && zero) begin
            next_pc = pc4 + branch_off;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        pc_out_d = pc_out_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ready) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    count_d  = count_q + 32'd1;
                    state_d  = ST_VALID;
                end
            end
            ST_VALID: begin
                // Decoder fields only matter on the edge that leaves VALID.
                if (!stall) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            valid_q  <= 1'b0;
            pc_out_q <= 32'd0;
            count_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            pc_out_q <= pc_out_d;
            count_q  <= count_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign InstrReg    = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed-vector bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall, branch, zero, jump;
    logic [15:0] const_imm;
    logic [25:0] address;
    logic        jump_j;
    logic [25:0] address_j;

    logic        imem_req,    imem_req_j,    imem_req_w;
    logic [31:0] imem_addr,   imem_addr_j,   imem_addr_w;
    logic [31:0] instr_reg,   instr_reg_j,   instr_reg_w;
    logic        instr_valid, instr_valid_j, instr_valid_w;
    logic [31:0] pc_out,      pc_out_j,      pc_out_w;
    logic [31:0] fetch_count, fetch_count_j, fetch_count_w;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrReg(instr_reg),
        .instr_valid(instr_valid), .pc_out(pc_out), .stall(stall), .branch(branch),
        .zero(zero), .jump(jump), .const_imm(const_imm), .address(address),
        .fetch_count(fetch_count)
    );

    instr_fetch #(.RESET_PC(32'h1000_0040)) dut_j (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req_j), .imem_addr(imem_addr_j),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrReg(instr_reg_j),
        .instr_valid(instr_valid_j), .pc_out(pc_out_j), .stall(stall), .branch(branch),
        .zero(zero), .jump(jump_j), .const_imm(const_imm), .address(address_j),
        .fetch_count(fetch_count_j)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrReg(instr_reg_w),
        .instr_valid(instr_valid_w), .pc_out(pc_out_w), .stall(stall), .branch(branch),
        .zero(zero), .jump(jump), .const_imm(const_imm), .address(address),
        .fetch_count(fetch_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"},   {31'd0, imem_req},    32'd0);
        check({tag, "_addr"},  imem_addr,            32'd0);
        check({tag, "_instr"}, instr_reg,            32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_pcout"}, pc_out,               32'd0);
        check({tag, "_count"}, fetch_count,          32'd0);
    endtask

    // Entered at a negedge in REQ; leaves at the negedge after capture (VALID).
    task automatic fetch(input string tag, input logic [31:0] word, input logic [31:0] pc_exp,
                         input logic [31:0] cnt_exp);
        check({tag, "_req"},  {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr,         pc_exp);
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        check({tag, "_instr"}, instr_reg,            word);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_pcout"}, pc_out,               pc_exp);
        check({tag, "_count"}, fetch_count,          cnt_exp);
        check({tag, "_vreq"},  {31'd0, imem_req},    32'd0);
    endtask

    task automatic leave(input string tag, input logic [31:0] addr_exp);
        stall = 1'b0;
        @(negedge clk);
        check({tag, "_nreq"},   {31'd0, imem_req},    32'd1);
        check({tag, "_naddr"},  imem_addr,            addr_exp);
        check({tag, "_nvalid"}, {31'd0, instr_valid}, 32'd0);
        branch = 1'b0; zero = 1'b0; jump = 1'b0; const_imm = 16'h0; address = 26'h0;
        jump_j = 1'b0; address_j = 26'h0;
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        const_imm = 16'h0; address = 26'h0; jump_j = 1'b0; address_j = 26'h0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset("rst_hold");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("start_req",  {31'd0, imem_req}, 32'd1);
        check("start_addr", imem_addr,         32'd0);

        fetch("seq0", 32'h2008_0005, 32'h0, 32'd1);
        check("j_pcout",  pc_out_j, 32'h1000_0040);
        check("w_pcout",  pc_out_w, 32'hFFFF_FFFC);
        jump_j = 1'b1; address_j = 26'h000_0100;
        leave("seq0", 32'h4);
`ifdef IFETCH_JUMP_EN
        check("j_target", imem_addr_j, 32'h1000_0400);
`else
        check("j_target", imem_addr_j, 32'h1000_0044);
`endif
        check("w_wrap", imem_addr_w, 32'h0000_0000);

        fetch("seq1", 32'h0109_5020, 32'h4, 32'd2);
        leave("seq1", 32'h8);
        fetch("seq2", 32'h1000_0000, 32'h8, 32'd3);
        leave("seq2", 32'hC);
        fetch("seq3", 32'h0000_0020, 32'hC, 32'd4);
        leave("seq3", 32'h10);

        fetch("br_fwd", 32'h1000_0003, 32'h10, 32'd5);
        branch = 1'b1; zero = 1'b1; const_imm = 16'h0003;
        leave("br_fwd", 32'h20);
        fetch("br_back", 32'h1000_FFFB, 32'h20, 32'd6);
        branch = 1'b1; zero = 1'b1; const_imm = 16'hFFFB;
        leave("br_back", 32'h10);
        fetch("br_self", 32'h1000_FFFF, 32'h10, 32'd7);
        branch = 1'b1; zero = 1'b1; const_imm = 16'hFFFF;
        leave("br_self", 32'h10);
        fetch("br_nz", 32'h1000_0003, 32'h10, 32'd8);
        branch = 1'b1; zero = 1'b0; const_imm = 16'h0003;
        jump = 1'b0;
        leave("br_nz", 32'h14);

        fetch("stall", 32'hAAAA_5555, 32'h14, 32'd9);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_instr", instr_reg,            32'hAAAA_5555);
            check("stall_pcout", pc_out,               32'h14);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_req",   {31'd0, imem_req},    32'd0);
        end
        leave("stall", 32'h18);

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("wait_req",   {31'd0, imem_req},    32'd1);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
            check("wait_instr", instr_reg,            32'hAAAA_5555);
            check("wait_count", fetch_count,          32'd9);
        end
        fetch("wait", 32'h1234_5678, 32'h18, 32'd10);
        leave("wait", 32'h1C);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_reset("rst_late");
        rst_n = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        check("post_instr", instr_reg,            32'd0);
        check("post_valid", {31'd0, instr_valid}, 32'd0);
        check("post_count", fetch_count,          32'd0);
        check("post_req",   {31'd0, imem_req},    32'd1);
        check("post_addr",  imem_addr,            32'd0);
        fetch("post", 32'h2008_0005, 32'h0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
